// File: rtl/division_entera_param.sv
// division_entera_param: N-bit radix-2 restoring divider with busy/done handshake, div0/ovf flags; signed mode built when DIV_SIGNED_EN is defined
module division_entera_param #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_mode,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic [N-1:0] Q,
    output logic [N-1:0] R,
    output logic         busy,
    output logic         done,
    output logic         div0,
    output logic         ovf
);
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, FIN} state_t;

    state_t        state, state_nx;
    logic [N-1:0]  a_r, b_r, dvd, rem, am, bm, rem_nx;
    logic [N:0]    sh;
    logic [CW-1:0] count;
    logic          ge, z, sa, sb;

`ifdef DIV_SIGNED_EN
    logic sm, ovf_c;
    assign sa    = sm & a_r[N-1];
    assign sb    = sm & b_r[N-1];
    assign ovf_c = sm && a_r == {1'b1, {(N-1){1'b0}}} && b_r == '1;
    // mode is captured with the operands; ovf clears on accept and is set when the result is published
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            sm  <= 1'b0;
            ovf <= 1'b0;
        end else if (state == IDLE && start) begin
            sm  <= signed_mode;
            ovf <= 1'b0;
        end else if (state == FIN)
            ovf <= ovf_c;
`else
    logic unused_signed_mode;
    assign unused_signed_mode = signed_mode;
    assign sa  = 1'b0;
    assign sb  = 1'b0;
    assign ovf = 1'b0;
`endif

    assign z      = b_r == '0;
    assign am     = sa ? -a_r : a_r;
    assign bm     = sb ? -b_r : b_r;
    assign sh     = {rem, dvd[N-1]};
    assign ge     = sh >= {1'b0, bm};
    assign rem_nx = ge ? N'(sh - {1'b0, bm}) : sh[N-1:0];
    assign busy   = state == CALC || state == FIN || done;

    // sequencing: zero divisor skips the iterations, otherwise N shift/subtract steps
    always_comb begin
        state_nx = state == IDLE ? (start ? LOAD : IDLE) :
                   state == LOAD ? (z ? FIN : CALC) :
                   state == CALC ? (count == CW'(1) ? FIN : CALC) : IDLE;
    end

    // operand capture, iteration datapath and registered result publication
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            dvd   <= '0;
            rem   <= '0;
            count <= '0;
            Q     <= '0;
            R     <= '0;
            done  <= 1'b0;
            div0  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= state == FIN;
            if (state == IDLE && start) begin
                a_r  <= A;
                b_r  <= B;
                div0 <= 1'b0;
            end
            if (state == LOAD) begin
                dvd   <= am;
                rem   <= '0;
                count <= CW'(N);
            end
            if (state == CALC) begin
                rem   <= rem_nx;
                dvd   <= {dvd[N-2:0], ge};
                count <= count - 1'b1;
            end
            if (state == FIN) begin
                Q    <= z ? '1 : (sa ^ sb) ? -dvd : dvd;
                R    <= z ? a_r : sa ? -rem : rem;
                div0 <= z;
            end
        end
endmodule

// File: tb/tb_division_entera_param.sv
// tb_division_entera_param: vector table, corner sequences and random ops against an arithmetic model
module tb_division_entera_param;
    logic       clk = 0, rst = 0, start = 0, signed_mode = 0;
    logic [7:0] A = 0, B = 0, Q, R;
    logic       busy, done, div0, ovf;
    int         pass_n = 0, tot_n = 0;

    typedef struct {
        logic [7:0] a, b;
        logic       sm;
        logic [7:0] q, r;
        logic       d0, ov;
    } vec_t;
    vec_t tv[9];

    always #5 clk = ~clk;

    division_entera_param #(.N(8)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .A(A), .B(B), .Q(Q), .R(R), .busy(busy), .done(done), .div0(div0), .ovf(ovf)
    );

    task automatic chk(input string nm, input int got, input int exp);
        tot_n++;
        if (got == exp) pass_n++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    function automatic void model(input logic [7:0] a, b, input logic sm,
                                  output logic [7:0] q, r, output logic d0, ov);
        int  sa, sb;
        bit  s;
`ifdef DIV_SIGNED_EN
        s = sm;
`else
        s = sm & 1'b0;
`endif
        d0 = 0;
        ov = 0;
        if (b == 0) begin
            q = 8'hFF; r = a; d0 = 1;
        end else if (s) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (sa == -128 && sb == -1) begin
                q = 8'h80; r = 0; ov = 1;
            end else begin
                q = 8'(sa / sb); r = 8'(sa % sb);
            end
        end else begin
            q = a / b; r = a % b;
        end
    endfunction

    task automatic run_op(input logic [7:0] a, b, input logic sm, input logic [7:0] eq, er,
                          input logic ed, eo, input int poke, input string nm);
        int cyc, el;
        bit busy_ok;
        el = (b == 0) ? 2 : 10;
        @(negedge clk);
        A = a; B = b; signed_mode = sm; start = 1;
        @(negedge clk);
        start = 0; A = 8'($urandom); B = 8'($urandom); signed_mode = ~sm;
        cyc = 0;
        busy_ok = 1;
        while (!done && cyc < 40) begin
            if (busy !== (cyc >= 1)) busy_ok = 0;
            start = (cyc == poke);
            if (cyc == poke) begin A = 1; B = 1; end
            @(negedge clk);
            cyc++;
        end
        start = 0;
        chk({nm, " latency"}, cyc, el);
        chk({nm, " busy"}, int'(busy_ok), 1);
        chk({nm, " Q"}, int'(Q), int'(eq));
        chk({nm, " R"}, int'(R), int'(er));
        chk({nm, " div0"}, int'(div0), int'(ed));
        chk({nm, " ovf"}, int'(ovf), int'(eo));
        chk({nm, " busy@done"}, int'(busy), 1);
        @(negedge clk);
        chk({nm, " done pulse"}, int'(done), 0);
    endtask

    initial begin
        logic [7:0] ra, rb, eq, er;
        logic       rs, ed, eo;
        int         cnt, g;
        tv[0] = '{8'd15,  8'd4,   1'b0, 8'd3,   8'd3,   1'b0, 1'b0};
        tv[1] = '{8'd7,   8'd0,   1'b0, 8'hFF,  8'd7,   1'b1, 1'b0};
        tv[2] = '{8'd9,   8'd3,   1'b0, 8'd3,   8'd0,   1'b0, 1'b0};
        tv[3] = '{8'd255, 8'd1,   1'b0, 8'd255, 8'd0,   1'b0, 1'b0};
        tv[4] = '{8'd3,   8'd200, 1'b0, 8'd0,   8'd3,   1'b0, 1'b0};
`ifdef DIV_SIGNED_EN
        tv[5] = '{8'hF1,  8'd4,   1'b1, 8'hFD,  8'hFD,  1'b0, 1'b0};
        tv[6] = '{8'h80,  8'hFF,  1'b1, 8'h80,  8'h00,  1'b0, 1'b1};
`else
        tv[5] = '{8'hF1,  8'd4,   1'b1, 8'd60,  8'd1,   1'b0, 1'b0};
        tv[6] = '{8'h80,  8'hFF,  1'b1, 8'h00,  8'h80,  1'b0, 1'b0};
`endif
        tv[7] = '{8'h85,  8'd0,   1'b1, 8'hFF,  8'h85,  1'b1, 1'b0};
        tv[8] = '{8'd0,   8'd5,   1'b0, 8'd0,   8'd0,   1'b0, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset Q", int'(Q), 0);
        chk("reset R", int'(R), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset div0", int'(div0), 0);
        chk("reset ovf", int'(ovf), 0);
        rst = 1;

        for (int i = 0; i < 9; i++)
            run_op(tv[i].a, tv[i].b, tv[i].sm, tv[i].q, tv[i].r, tv[i].d0, tv[i].ov, -1,
                   $sformatf("vec%0d", i));

        run_op(8'd15, 8'd4, 1'b0, 8'd3, 8'd3, 1'b0, 1'b0, 4, "start during CALC");
        cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("no extra done", cnt, 0);

        @(negedge clk);
        A = 8'd100; B = 8'd7; signed_mode = 0; start = 1;
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        rst = 0;
        #1;
        chk("midrst Q", int'(Q), 0);
        chk("midrst R", int'(R), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst div0", int'(div0), 0);
        cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (done) cnt++;
        end
        rst = 1;
        repeat (12) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("midrst no done", cnt, 0);
        run_op(8'd15, 8'd4, 1'b0, 8'd3, 8'd3, 1'b0, 1'b0, -1, "after reset");

        @(negedge clk);
        A = 8'd20; B = 8'd6; signed_mode = 0; start = 1;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!done && g < 40);
        chk("held first Q", int'(Q), 3);
        chk("held first R", int'(R), 2);
        A = 8'd50; B = 8'd7;
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!done && g < 40);
        start = 0;
        chk("held gap", g, 11);
        chk("held second Q", int'(Q), 7);
        chk("held second R", int'(R), 1);

        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 4) == 0) ? 8'h80 : 8'($urandom);
            case ($urandom_range(0, 5))
                0: rb = 8'h00;
                1: rb = 8'hFF;
                default: rb = 8'($urandom);
            endcase
            rs = 1'($urandom);
            model(ra, rb, rs, eq, er, ed, eo);
            run_op(ra, rb, rs, eq, er, ed, eo, -1, $sformatf("rnd%0d %0d/%0d s%0d", i, ra, rb, rs));
        end

        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end
endmodule
